// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM arbiter/controller: FSM states, default
// bus widths and active-low strobe levels.
package sram_pkg;

  localparam int AW_DEF = 4;
  localparam int DW_DEF = 8;

  localparam logic ASSERT_L   = 1'b0;
  localparam logic DEASSERT_L = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_PULSE,
    W_HOLD,
    R_SETUP,
    R_WAIT,
    R_END
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last
// time is granted. Grant is one-hot, combinational, and gated by en.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = '0;
    if (en) begin
      if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  // Reset to 1 so requester 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst)       last <= 1'b1;
    else if (|gnt) last <= gnt[1];
  end

endmodule

// File: rtl/sram_arb_ctrl.sv
// Synchronous front end for a small asynchronous RAM: arbitrates two
// requesters and sequences registered ceb/web/oeb strobes and the data bus.
module sram_arb_ctrl
  import sram_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int WP_CYC = 2,
  parameter int RD_CYC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          done0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] ram_addr,
  inout  wire  logic [DW-1:0] ram_data,
  output logic          ram_ceb,
  output logic          ram_web,
  output logic          ram_oeb
);

  localparam int MAXC = (WP_CYC > RD_CYC) ? WP_CYC : RD_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] WP_LD = CW'(WP_CYC - 1);
  localparam logic [CW-1:0] RD_LD = CW'(RD_CYC - 1);

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    gnt;
  logic          own;
  logic          drv;
  logic [DW-1:0] dout;

  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          ceb_on, web_on, oeb_on, drv_on, fin;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (state == IDLE),
    .req ({req1, req0}),
    .gnt (gnt)
  );

  // Pin levels are derived from the next state and registered, so every
  // RAM pin changes only on a clock edge and lines up with the state.
  always_comb begin
    nxt       = state;
    sel_we    = gnt[1] ? we1    : we0;
    sel_addr  = gnt[1] ? addr1  : addr0;
    sel_wdata = gnt[1] ? wdata1 : wdata0;
    case (state)
      IDLE:    if (|gnt) nxt = sel_we ? W_SETUP : R_SETUP;
      W_SETUP: nxt = W_PULSE;
      W_PULSE: if (cnt == '0) nxt = W_HOLD;
      W_HOLD:  nxt = IDLE;
      R_SETUP: nxt = R_WAIT;
      R_WAIT:  if (cnt == '0) nxt = R_END;
      R_END:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
    ceb_on = nxt inside {W_SETUP, W_PULSE, R_SETUP, R_WAIT};
    web_on = (nxt == W_PULSE);
    oeb_on = nxt inside {R_SETUP, R_WAIT};
    drv_on = nxt inside {W_SETUP, W_PULSE, W_HOLD};
    fin    = nxt inside {W_HOLD, R_END};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)                                           cnt <= '0;
    else if (state == W_SETUP)                         cnt <= WP_LD;
    else if (state == R_SETUP)                         cnt <= RD_LD;
    else if (state inside {W_PULSE, R_WAIT} && cnt != '0) cnt <= cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_ceb  <= DEASSERT_L;
      ram_web  <= DEASSERT_L;
      ram_oeb  <= DEASSERT_L;
      ram_addr <= '0;
      drv      <= 1'b0;
      dout     <= '0;
      own      <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      rdata    <= '0;
    end else begin
      ram_ceb <= ceb_on ? ASSERT_L : DEASSERT_L;
      ram_web <= web_on ? ASSERT_L : DEASSERT_L;
      ram_oeb <= oeb_on ? ASSERT_L : DEASSERT_L;
      drv     <= drv_on;
      done0   <= fin & ~own;
      done1   <= fin & own;
      if (|gnt) begin
        own      <= gnt[1];
        ram_addr <= sel_addr;
        dout     <= sel_wdata;
      end
      if (state == R_WAIT && nxt == R_END) rdata <= ram_data;
    end
  end

  assign ram_data = drv ? dout : 'z;

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Bench for sram_arb_ctrl: async RAM model, access-level reference model and
// queued requester drivers; directed scenarios followed by random traffic.
module tb_sram_arb_ctrl;

  localparam int unsigned WP  = 3;
  localparam int unsigned RD  = 2;
  localparam time         PER = 10;

  typedef struct packed {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
  } op_t;

  logic       clk;
  logic       rst;
  logic       req0, we0, req1, we1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       done0, done1;
  logic [7:0] rdata;
  logic [3:0] ram_addr;
  wire  [7:0] ram_data;
  logic       ram_ceb, ram_web, ram_oeb;

  sram_arb_ctrl #(.AW(4), .DW(8), .WP_CYC(WP), .RD_CYC(RD)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .done0(done0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .done1(done1),
    .rdata(rdata), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_ceb(ram_ceb), .ram_web(ram_web), .ram_oeb(ram_oeb)
  );

  initial begin
    clk = 1'b0;
    forever #(PER/2) clk = ~clk;
  end

  // Asynchronous RAM: drives while ceb/oeb low; a write lands on the rising
  // web edge only if web stayed low for a full write pulse.
  logic [7:0] mem [16];
  assign ram_data = (!ram_ceb && !ram_oeb) ? mem[ram_addr] : 'z;

  initial begin : ram_model
    time t_fall;
    bit  fell;
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    fell   = 1'b0;
    t_fall = 0;
    forever begin
      @(ram_web);
      if (ram_web == 1'b0) begin
        fell   = 1'b1;
        t_fall = $time;
      end else if (fell && ($time - t_fall >= WP * PER)) begin
        mem[ram_addr] = ram_data;
      end
    end
  end

  // Reference model, one access at a time: cycle c counts from 1 after the
  // grant edge, L = 2 + pulse length; done in cycle L, then one idle cycle.
  logic [7:0]  ref_mem [16];
  bit          m_valid, m_act, m_own, m_last;
  int unsigned m_c, m_L, cyc;
  op_t         m_op;
  logic [3:0]  m_addr;
  logic [7:0]  m_rdata;

  initial begin : ref_model
    m_valid = 1'b0; m_act = 1'b0; m_last = 1'b1; m_own = 1'b0;
    m_c = 0; m_L = 0; cyc = 0; m_op = '0; m_addr = '0; m_rdata = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        if (!m_valid) for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];
        m_valid = 1'b1; m_act = 1'b0; m_last = 1'b1;
        m_addr = '0; m_rdata = '0;
      end else if (m_act) begin
        m_c++;
        if (m_c == m_L) begin
          if (m_op.we) ref_mem[m_op.addr] = m_op.wdata;
          else         m_rdata = ref_mem[m_op.addr];
        end
        if (m_c > m_L) m_act = 1'b0;
      end else if (req0 || req1) begin
        m_own  = (req0 && req1) ? !m_last : req1;
        m_last = m_own;
        m_op   = m_own ? {we1, addr1, wdata1} : {we0, addr0, wdata0};
        m_addr = m_op.addr;
        m_L    = 2 + (m_op.we ? WP : RD);
        m_c    = 1;
        m_act  = 1'b1;
      end
    end
  end

  int unsigned n_vec, n_err;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  function automatic op_t mk(input logic we, input logic [3:0] a, input logic [7:0] d);
    op_t o;
    o.we = we; o.addr = a; o.wdata = d;
    return o;
  endfunction

  // Requester drivers and bench-side bookkeeping, all stepped from tick()
  op_t         q0[$], q1[$];
  bit          ph[2];
  int unsigned gap[2], wt[2];
  int unsigned max_gap;
  bit          abort_ok;
  int unsigned dl_own[$], dl_cyc[$];
  int unsigned ceb_run, web_run, oeb_run, last_ceb, last_web, last_oeb;

  task automatic set_req(input int unsigned id, input logic v);
    if (id == 0) req0 = v; else req1 = v;
  endtask

  function automatic int unsigned qn(input int unsigned id);
    return (id == 0) ? q0.size() : q1.size();
  endfunction

  task automatic step_req(input int unsigned id);
    op_t  op;
    logic dn;
    dn = (id == 0) ? done0 : done1;
    if (ph[id]) begin
      if (dn) begin
        ph[id]  = 1'b0;
        gap[id] = $urandom_range(max_gap, 0);
        if (qn(id) == 0 || gap[id] != 0) set_req(id, 1'b0);
      end else if (rst) begin
        if (abort_ok) begin ph[id] = 1'b0; set_req(id, 1'b0); end
      end else begin
        wt[id]++;
        if (wt[id] > 40) begin
          chk(id == 0 ? "done0_timeout" : "done1_timeout", wt[id], 40);
          ph[id] = 1'b0;
          set_req(id, 1'b0);
        end
      end
    end else if (gap[id] != 0) begin
      gap[id]--;
    end else if (qn(id) != 0) begin
      if (id == 0) begin
        op = q0.pop_front(); we0 = op.we; addr0 = op.addr; wdata0 = op.wdata;
      end else begin
        op = q1.pop_front(); we1 = op.we; addr1 = op.addr; wdata1 = op.wdata;
      end
      set_req(id, 1'b1);
      ph[id] = 1'b1;
      wt[id] = 0;
    end
  endtask

  task automatic tick();
    logic e_ceb, e_web, e_oeb, e_d0, e_d1;
    @(negedge clk);
    if (m_valid) begin
      e_ceb = !(m_act && m_c <= m_L - 1);
      e_web = !(m_act && m_op.we && m_c >= 2 && m_c <= m_L - 1);
      e_oeb = !(m_act && !m_op.we && m_c <= m_L - 1);
      e_d0  = m_act && m_c == m_L && !m_own;
      e_d1  = m_act && m_c == m_L && m_own;
      chk("ram_ceb", ram_ceb, e_ceb);
      chk("ram_web", ram_web, e_web);
      chk("ram_oeb", ram_oeb, e_oeb);
      chk("done0", done0, e_d0);
      chk("done1", done1, e_d1);
      chk("rdata", rdata, m_rdata);
      chk("ram_addr", ram_addr, m_addr);
      if (m_act && m_op.we) chk("wr_bus", ram_data, m_op.wdata);
      chk("web_outside_ceb", !ram_web && ram_ceb, 1'b0);
      chk("oeb_during_write", !ram_oeb && !ram_web, 1'b0);
      chk("done_overlap", done0 && done1, 1'b0);
      if (done0) begin dl_own.push_back(0); dl_cyc.push_back(cyc); end
      if (done1) begin dl_own.push_back(1); dl_cyc.push_back(cyc); end
      if (!ram_ceb) ceb_run++; else if (ceb_run != 0) begin last_ceb = ceb_run; ceb_run = 0; end
      if (!ram_web) web_run++; else if (web_run != 0) begin last_web = web_run; web_run = 0; end
      if (!ram_oeb) oeb_run++; else if (oeb_run != 0) begin last_oeb = oeb_run; oeb_run = 0; end
    end
    step_req(0);
    step_req(1);
  endtask

  task automatic wait_quiet(input int unsigned budget);
    int unsigned n;
    n = 0;
    while (q0.size() != 0 || q1.size() != 0 || ph[0] || ph[1] || m_act) begin
      if (n == budget) begin
        chk("quiet_timeout", n, 0);
        return;
      end
      tick();
      n++;
    end
    tick();
  endtask

  initial begin : main
    int unsigned base;
    logic [7:0]  pre;
    bit          hit;
    op_t         op;
    n_vec = 0; n_err = 0;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    max_gap = 0; abort_ok = 1'b0;
    ceb_run = 0; web_run = 0; oeb_run = 0; last_ceb = 0; last_web = 0; last_oeb = 0;
    repeat (3) tick();
    rst = 1'b0;

    q0.push_back(mk(1'b1, 4'h0, 8'h01));
    wait_quiet(100);
    chk("t1_ceb_len", last_ceb, 1 + WP);
    chk("t1_web_len", last_web, WP);

    q1.push_back(mk(1'b0, 4'h0, 8'h00));
    wait_quiet(100);
    chk("t2_oeb_len", last_oeb, 1 + RD);
    chk("t2_rdata", rdata, 8'h01);

    q0.push_back(mk(1'b1, 4'h9, 8'hA5));
    q0.push_back(mk(1'b0, 4'h9, 8'h00));
    wait_quiet(100);
    chk("t3_rdata", rdata, 8'hA5);
    q1.push_back(mk(1'b0, 4'hE, 8'h00));
    wait_quiet(100);
    chk("t3_unwritten", rdata, ref_mem[14]);

    // Both requesters hold req from reset onward
    rst = 1'b1;
    q0.push_back(mk(1'b1, 4'h3, 8'h11));
    q0.push_back(mk(1'b1, 4'h3, 8'h12));
    q1.push_back(mk(1'b1, 4'h4, 8'h21));
    q1.push_back(mk(1'b1, 4'h4, 8'h22));
    base = dl_own.size();
    repeat (2) tick();
    rst = 1'b0;
    wait_quiet(200);
    chk("rr_count", dl_own.size() - base, 4);
    if (dl_own.size() >= base + 4) begin
      for (int k = 0; k < 4; k++) chk("rr_order", dl_own[base + k], k % 2);
      for (int k = 0; k < 3; k++) chk("rr_gap", dl_cyc[base + k + 1] - dl_cyc[base + k], 3 + WP);
    end

    // Reset during the second web-low cycle of a write to address 5
    pre = ref_mem[5];
    abort_ok = 1'b1;
    q0.push_back(mk(1'b1, 4'h5, 8'h3C));
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick();
      hit = m_act && m_op.we && m_c == 3;
    end
    chk("abort_reached", hit, 1'b1);
    base = dl_own.size();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    abort_ok = 1'b0;
    chk("abort_no_done", dl_own.size(), base);
    q1.push_back(mk(1'b0, 4'h5, 8'h00));
    wait_quiet(100);
    chk("abort_pre_value", rdata, pre);

    max_gap = 3;
    for (int i = 0; i < 80; i++) begin
      op = mk(1'($urandom), 4'($urandom), 8'($urandom));
      if ($urandom_range(1, 0) == 0) q0.push_back(op);
      else                           q1.push_back(op);
    end
    wait_quiet(4000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
